load_scoreboard_ctrl: RTL

- Issue-stage scoreboard for the 5-stage RISC-V core.
- Tracks destination registers of outstanding variable-latency loads.
- Stalls ID on RAW/WAW hazards against those loads, and flags same-cycle load-return bypass to the ID operand muxes.
- Sits beside the forwarding units: it sequences instruction issue, while the forwarding units handle the fixed-latency EX/MEM/WB paths.

---
 rtl/load_scoreboard_ctrl.sv | 115 +++++++++++
 1 files changed

// File: rtl/load_scoreboard_ctrl.sv
// Issue-stage scoreboard for outstanding variable-latency loads: stalls ID on
// RAW/WAW/capacity hazards and flags same-cycle load-return bypass.
module load_scoreboard_ctrl #(
   parameter int MAX_OUTSTANDING = 4,
   parameter int CNT_W           = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_uses_rs2,
   input  logic [4:0]       id_rd,
   input  logic             id_reg_we,
   input  logic             id_is_load,
   input  logic             id_flush,
   input  logic             ld_done,
   input  logic [4:0]       ld_rd,
   output logic             stall,
   output logic             issue,
   output logic             byp_rs1,
   output logic             byp_rs2,
   output logic             busy,
   output logic [3:0]       outstanding,
   output logic [CNT_W-1:0] stall_cycles,
   output logic             err_underflow
);

   localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

   logic [31:1]      pending_bits_reg;
   logic [31:1]      pending_bits_next;
   logic [31:0]      pending;
   logic [3:0]       outstanding_reg;
   logic [3:0]       outstanding_next;
   logic [CNT_W-1:0] stall_cycles_reg;
   logic             err_underflow_reg;
   logic             err_underflow_next;

   logic ret_rs1, ret_rs2, ret_rd;
   logic pend_rs1, pend_rs2, pend_rd;
   logic raw1, raw2, waw, full;
   logic load_issue;

   // x0 can never be pending
   assign pending = {pending_bits_reg, 1'b0};

   assign pend_rs1 = (id_rs1 != 5'd0) && pending[id_rs1];
   assign pend_rs2 = (id_rs2 != 5'd0) && pending[id_rs2];
   assign pend_rd  = (id_rd  != 5'd0) && pending[id_rd];

   assign ret_rs1 = ld_done && (ld_rd == id_rs1) && (id_rs1 != 5'd0);
   assign ret_rs2 = ld_done && (ld_rd == id_rs2) && (id_rs2 != 5'd0);
   assign ret_rd  = ld_done && (ld_rd == id_rd)  && (id_rd  != 5'd0);

   assign raw1 = pend_rs1 && !ret_rs1;
   assign raw2 = id_uses_rs2 && pend_rs2 && !ret_rs2;
   assign waw  = id_reg_we && pend_rd && !ret_rd;
   // A returning load frees a slot in the same cycle, so capacity is not a hazard then
   assign full = id_is_load && (outstanding_reg == MAX_CNT) && !ld_done;

   assign stall   = id_valid && !id_flush && (raw1 || raw2 || waw || full);
   assign issue   = id_valid && !id_flush && !stall;
   assign byp_rs1 = id_valid && pend_rs1 && ret_rs1;
   assign byp_rs2 = id_valid && id_uses_rs2 && pend_rs2 && ret_rs2;

   assign load_issue = issue && id_is_load;

   genvar gi;
   generate
      for (gi = 1; gi < 32; gi++) begin : g_pending
         logic set_bit;
         logic clr_bit;
         assign set_bit = load_issue && (id_rd == 5'(gi));
         assign clr_bit = ld_done && (ld_rd == 5'(gi));
         // Set has priority so a reissued load to the same rd stays tracked
         assign pending_bits_next[gi] = set_bit || (pending_bits_reg[gi] && !clr_bit);
      end
   endgenerate

   always_comb begin
      outstanding_next   = outstanding_reg;
      err_underflow_next = err_underflow_reg;
      if (ld_done && (outstanding_reg == 4'd0)) begin
         err_underflow_next = 1'b1;
      end
      if (load_issue && !ld_done) begin
         outstanding_next = outstanding_reg + 4'd1;
      end else if (!load_issue && ld_done && (outstanding_reg != 4'd0)) begin
         outstanding_next = outstanding_reg - 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_bits_reg  <= '0;
         outstanding_reg   <= 4'd0;
         err_underflow_reg <= 1'b0;
         stall_cycles_reg  <= '0;
      end else begin
         pending_bits_reg  <= pending_bits_next;
         outstanding_reg   <= outstanding_next;
         err_underflow_reg <= err_underflow_next;
         if (stall && !(&stall_cycles_reg)) begin
            stall_cycles_reg <= stall_cycles_reg + CNT_W'(1);
         end
      end
   end

   assign outstanding   = outstanding_reg;
   assign busy          = (outstanding_reg != 4'd0);
   assign stall_cycles  = stall_cycles_reg;
   assign err_underflow = err_underflow_reg;

endmodule
